hbridge_gate_drv: RTL and testbench
===================================

// Module: hbridge_gate_drv
// PURPOSE
//  Gate-drive generator for N half-bridge legs in the power unit: up/down gate pairs per leg.
//  Per-leg dead-time insertion, latched unit fault, start/stop gating.
//  Sits between the modulator (leg commands) and the IGBT driver pins.
//  Generalises the 2-leg fixed-pattern driver: N legs, parametric dead time, fault latch/clear.
// PARAMETERS
//  N_LEG       2    number of half-bridge legs (1..8)
//  CNT_W       9    dead-time / min-pulse counter width
//  DEAD_CYC    50   dead-time clocks, both gates low (0..2^CNT_W-1; 0 = direct switch)
//  MIN_ON_CYC  20   minimum gate-on clocks; only used with GATE_MIN_PULSE_EN
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous active-low reset
//  err_unit   in   1      unit fault, level; sets fault latch
//  fault_clr  in   1      one-cycle pulse; clears latch if err_unit==0 and start_stop==0
//  start_stop in   1      1 = run, 0 = stop (all gates off)
//  leg_en     in   N_LEG  per-leg enable; 0 = both gates of that leg off
//  leg_cmd    in   N_LEG  per-leg command; 1 = upper on, 0 = lower on
//  gate_up    out  N_LEG  upper gate drive, 1 = IGBT on
//  gate_dn    out  N_LEG  lower gate drive, 1 = IGBT on
//  leg_dead   out  N_LEG  1 while leg is in dead-time state
//  fault_o    out  1      fault latch state
// BEHAVIOUR
//  Reset: gate_up=0, gate_dn=0, leg_dead=0, fault_o=0, all legs OFF, counters 0.
//  Fault latch: set at the first edge with err_unit==1.
//   Clear: fault_clr==1 && err_unit==0 && start_stop==0. Set wins over clear.
//  run = start_stop & ~fault_o_next. All outputs are registered.
//  Per-leg FSM, states OFF / UP / DN / DEAD:
//   any state: !run | !leg_en -> OFF. Gates low on that same edge; counter cleared.
//   OFF: run & leg_en -> DEAD. tgt=leg_cmd, counter loaded.
//   UP: leg_cmd==0 -> DEAD, tgt=DN. gate_up falls on that edge.
//   DN: leg_cmd==1 -> DEAD, tgt=UP. gate_dn falls on that edge.
//   DEAD: both gates low for exactly DEAD_CYC cycles, then enter tgt (its gate rises).
//    tgt tracks leg_cmd during DEAD; counter is not restarted.
//    A command reverting mid-dead completes the dead time, then turns on the reverted side.
//  DEAD_CYC==0: the old gate falls and the new gate rises on the same edge; DEAD is skipped.
//  Invariant: gate_up[i] & gate_dn[i] never 1 simultaneously, including reset and fault.
//  Counter saturates; it never wraps.
//  Reset asserted mid-operation: all gates low immediately (asynchronous).
// CONFIGURATION
//  GATE_MIN_PULSE_EN defined:
//   after entering UP or DN, a leg ignores leg_cmd changes for MIN_ON_CYC cycles.
//   A pending change is acted on when that window expires, if still present.
//   Stop, fault, reset and leg_en=0 remain immediate.
//  GATE_MIN_PULSE_EN undefined: no minimum on-time; MIN_ON_CYC is unused; no on-timer logic.
// STRUCTURE
//  Package hbridge_gate_pkg: leg state encoding (OFF/UP/DN/DEAD), default CNT_W/DEAD_CYC.
//  Sub-module hbridge_leg_fsm: one leg (FSM, dead/min-on counter, gate regs).
//   Instantiated N_LEG times via generate.
//  Top level holds the fault latch and the run derivation.
// TESTING
//  1. DEAD_CYC=5, run, leg_cmd[0] 1->0 -> gate_up[0] low next edge, both low 5 cyc, gate_dn[0] high.
//  2. leg_cmd toggles 1->0->1 within 2 cycles of DEAD -> 5 dead cycles, then gate_up high again.
//  3. err_unit pulse 1 cyc while running -> all gates 0 next edge, fault_o=1.
//     fault_clr with start_stop=1 ignored; clears with start_stop=0.
//  4. start_stop 0->1, leg_en=2'b11, cmd=2'b10 -> both legs DEAD 5 cyc, then up[1]=1, dn[0]=1.
//  5. DEAD_CYC=0, cmd toggle -> gate swap on one edge, never both high.
//  6. GATE_MIN_PULSE_EN, MIN_ON_CYC=20, cmd change at cycle 3 of UP -> DEAD starts at cycle 20.
//  All tests: concurrent assertion !(gate_up[i] & gate_dn[i]) for every leg, every cycle.

Source files
------------

// File: rtl/hbridge_gate_pkg.sv
// rtl/hbridge_gate_pkg.sv - leg state encoding and default timing for the H-bridge gate driver
package hbridge_gate_pkg;

  typedef enum logic [1:0] {
    LEG_OFF  = 2'd0,
    LEG_UP   = 2'd1,
    LEG_DN   = 2'd2,
    LEG_DEAD = 2'd3
  } leg_state_e;

  localparam int DEF_CNT_W    = 9;
  localparam int DEF_DEAD_CYC = 50;
`ifdef GATE_MIN_PULSE_EN
  localparam int DEF_MIN_ON_CYC = 20;
`endif

endpackage

// File: rtl/hbridge_leg_fsm.sv
// rtl/hbridge_leg_fsm.sv - one half-bridge leg: state machine, dead/min-on counter, gate regs (GATE_MIN_PULSE_EN adds min on-time)
module hbridge_leg_fsm import hbridge_gate_pkg::*; #(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int DEAD_CYC = DEF_DEAD_CYC
`ifdef GATE_MIN_PULSE_EN
  , parameter int MIN_ON_CYC = DEF_MIN_ON_CYC
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic leg_en,
  input  logic leg_cmd,
  output logic gate_up,
  output logic gate_dn,
  output logic leg_dead
);

  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
`ifdef GATE_MIN_PULSE_EN
  // Loaded on entry to UP/DN so the counter reaches zero after MIN_ON_CYC edges
  localparam logic [CNT_W-1:0] MIN_LOAD  = (MIN_ON_CYC > 0) ? CNT_W'(MIN_ON_CYC - 1) : '0;
`else
  localparam logic [CNT_W-1:0] MIN_LOAD  = '0;
`endif

  leg_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             on_done;
  logic             want_switch;

`ifdef GATE_MIN_PULSE_EN
  assign on_done = (cnt == '0);
`else
  assign on_done = 1'b1;
`endif

  // Decide whether the current conducting/idle state must move toward the commanded side
  always_comb begin
    want_switch = 1'b0;
    case (state)
      LEG_OFF: want_switch = 1'b1;
      LEG_UP:  want_switch = !leg_cmd && on_done;
      LEG_DN:  want_switch = leg_cmd && on_done;
      default: want_switch = 1'b0;
    endcase
  end

  // Leg state machine with registered gate outputs; the dead-time target is leg_cmd sampled at expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LEG_OFF;
      cnt      <= '0;
      gate_up  <= 1'b0;
      gate_dn  <= 1'b0;
      leg_dead <= 1'b0;
    end else if (!run || !leg_en) begin
      state    <= LEG_OFF;
      cnt      <= '0;
      gate_up  <= 1'b0;
      gate_dn  <= 1'b0;
      leg_dead <= 1'b0;
    end else if (state == LEG_DEAD) begin
      if (cnt <= ONE) begin
        state    <= leg_cmd ? LEG_UP : LEG_DN;
        gate_up  <= leg_cmd;
        gate_dn  <= !leg_cmd;
        leg_dead <= 1'b0;
        cnt      <= MIN_LOAD;
      end else begin
        cnt <= cnt - ONE;
      end
    end else if (want_switch) begin
      if (DEAD_CYC == 0) begin
        state    <= leg_cmd ? LEG_UP : LEG_DN;
        gate_up  <= leg_cmd;
        gate_dn  <= !leg_cmd;
        leg_dead <= 1'b0;
        cnt      <= MIN_LOAD;
      end else begin
        state    <= LEG_DEAD;
        gate_up  <= 1'b0;
        gate_dn  <= 1'b0;
        leg_dead <= 1'b1;
        cnt      <= DEAD_LOAD;
      end
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

endmodule

// File: rtl/hbridge_gate_drv.sv
// rtl/hbridge_gate_drv.sv - N-leg H-bridge gate driver top: fault latch, run gating, leg array (GATE_MIN_PULSE_EN optional)
module hbridge_gate_drv import hbridge_gate_pkg::*; #(
  parameter int N_LEG    = 2,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int DEAD_CYC = DEF_DEAD_CYC
`ifdef GATE_MIN_PULSE_EN
  , parameter int MIN_ON_CYC = DEF_MIN_ON_CYC
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             err_unit,
  input  logic             fault_clr,
  input  logic             start_stop,
  input  logic [N_LEG-1:0] leg_en,
  input  logic [N_LEG-1:0] leg_cmd,
  output logic [N_LEG-1:0] gate_up,
  output logic [N_LEG-1:0] gate_dn,
  output logic [N_LEG-1:0] leg_dead,
  output logic             fault_o
);

  logic fault_next;
  logic run;

  // A fault present this cycle wins over a clear request; clearing only while stopped
  assign fault_next = err_unit | (fault_o & !(fault_clr & !start_stop));
  assign run        = start_stop & !fault_next;

  // Unit fault latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_o <= 1'b0;
    else        fault_o <= fault_next;
  end

  for (genvar i = 0; i < N_LEG; i++) begin : g_leg
    hbridge_leg_fsm #(
      .CNT_W    (CNT_W),
      .DEAD_CYC (DEAD_CYC)
`ifdef GATE_MIN_PULSE_EN
      , .MIN_ON_CYC (MIN_ON_CYC)
`endif
    ) u_leg (
      .clk      (clk),
      .rst_n    (rst_n),
      .run      (run),
      .leg_en   (leg_en[i]),
      .leg_cmd  (leg_cmd[i]),
      .gate_up  (gate_up[i]),
      .gate_dn  (gate_dn[i]),
      .leg_dead (leg_dead[i])
    );
  end

endmodule

// File: tb/tb_hbridge_gate_drv.sv
// tb/tb_hbridge_gate_drv.sv - directed bench for hbridge_gate_drv (GATE_MIN_PULSE_EN adds min on-time steps)
module tb_hbridge_gate_drv;

  logic       clk = 1'b0;
  logic       rst_n, err_unit, fault_clr, start_stop;
  logic [1:0] leg_en, leg_cmd;

  logic [1:0] up5, dn5, dead5;
  logic       flt5;
  logic [1:0] up0, dn0, dead0;
  logic       flt0;
  logic [6:0] s5, s0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hbridge_gate_drv #(
    .N_LEG(2), .CNT_W(9), .DEAD_CYC(5)
`ifdef GATE_MIN_PULSE_EN
    , .MIN_ON_CYC(0)
`endif
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .err_unit(err_unit), .fault_clr(fault_clr),
    .start_stop(start_stop), .leg_en(leg_en), .leg_cmd(leg_cmd),
    .gate_up(up5), .gate_dn(dn5), .leg_dead(dead5), .fault_o(flt5)
  );

  hbridge_gate_drv #(
    .N_LEG(2), .CNT_W(9), .DEAD_CYC(0)
`ifdef GATE_MIN_PULSE_EN
    , .MIN_ON_CYC(0)
`endif
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .err_unit(err_unit), .fault_clr(fault_clr),
    .start_stop(start_stop), .leg_en(leg_en), .leg_cmd(leg_cmd),
    .gate_up(up0), .gate_dn(dn0), .leg_dead(dead0), .fault_o(flt0)
  );

  assign s5 = {up5, dn5, dead5, flt5};
  assign s0 = {up0, dn0, dead0, flt0};

`ifdef GATE_MIN_PULSE_EN
  logic [1:0] upm, dnm, deadm;
  logic       fltm;
  logic [6:0] sm;

  hbridge_gate_drv #(
    .N_LEG(2), .CNT_W(9), .DEAD_CYC(5), .MIN_ON_CYC(20)
  ) u_dutm (
    .clk(clk), .rst_n(rst_n), .err_unit(err_unit), .fault_clr(fault_clr),
    .start_stop(start_stop), .leg_en(leg_en), .leg_cmd(leg_cmd),
    .gate_up(upm), .gate_dn(dnm), .leg_dead(deadm), .fault_o(fltm)
  );

  assign sm = {upm, dnm, deadm, fltm};

  // Shoot-through check on the min-pulse instance
  always @(negedge clk) begin
    n_vec++;
    assert ((upm & dnm) === 2'b00) else begin
      n_err++;
      $error("FAIL shoot_through_m up=%b dn=%b expected overlap 00", upm, dnm);
    end
  end
`endif

  // Shoot-through check on every leg of the main instances, every cycle
  always @(negedge clk) begin
    n_vec++;
    assert (((up5 & dn5) | (up0 & dn0)) === 2'b00) else begin
      n_err++;
      $error("FAIL shoot_through up5=%b dn5=%b up0=%b dn0=%b expected overlap 00", up5, dn5, up0, dn0);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; err_unit = 1'b0; fault_clr = 1'b0; start_stop = 1'b0;
    leg_en = 2'b00; leg_cmd = 2'b00;
    tick(2);
    chk("reset_state", s5, 7'b0000000);
    chk("reset_state0", s0, 7'b0000000);
    rst_n = 1'b1;

    // 1: enter UP through dead time, then switch to DN
    leg_en = 2'b01; leg_cmd = 2'b01; start_stop = 1'b1;
    tick();  chk("t1_enter_dead", s5, 7'b0000010);
    tick(4); chk("t1_dead_c4", s5, 7'b0000010);
    tick();  chk("t1_up_on", s5, 7'b0100000);
    leg_cmd = 2'b00;
    tick();  chk("t1_up_fall", s5, 7'b0000010);
    tick(4); chk("t1_dead_hold", s5, 7'b0000010);
    tick();  chk("t1_dn_on", s5, 7'b0001000);

    // 2: back to UP, then a command glitch inside dead time
    leg_cmd = 2'b01;
    tick(6); chk("t2_up_again", s5, 7'b0100000);
    leg_cmd = 2'b00;
    tick();  chk("t2_dead_start", s5, 7'b0000010);
    leg_cmd = 2'b01;
    tick();  chk("t2_revert_dead", s5, 7'b0000010);
    tick(3); chk("t2_dead_no_restart", s5, 7'b0000010);
    tick();  chk("t2_up_restored", s5, 7'b0100000);

    // 3: fault latch set, clear rules
    err_unit = 1'b1;
    tick();  chk("t3_fault_set", s5, 7'b0000001);
    err_unit = 1'b0;
    tick();  chk("t3_fault_held", s5, 7'b0000001);
    fault_clr = 1'b1;
    tick();  chk("t3_clr_while_run", s5, 7'b0000001);
    fault_clr = 1'b0; start_stop = 1'b0; err_unit = 1'b1; fault_clr = 1'b1;
    tick();  chk("t3_set_wins", s5, 7'b0000001);
    err_unit = 1'b0;
    tick();  chk("t3_clr_stopped", s5, 7'b0000000);
    fault_clr = 1'b0;

    // 4: both legs start together
    leg_en = 2'b11; leg_cmd = 2'b10; start_stop = 1'b1;
    tick();  chk("t4_both_dead", s5, 7'b0000110);
    chk("t5_direct_start0", s0, 7'b1001000);
    tick(4); chk("t4_both_dead_c4", s5, 7'b0000110);
    tick();  chk("t4_both_on", s5, 7'b1001000);

    // 5: zero dead time swaps on one edge
    leg_cmd = 2'b01;
    tick();  chk("t5_swap0", s0, 7'b0110000);
    chk("t5_main_dead", s5, 7'b0000110);
    leg_cmd = 2'b10;
    tick();  chk("t5_swap_back0", s0, 7'b1001000);
    tick(3); chk("t5_main_revert_dead", s5, 7'b0000110);
    tick();  chk("t5_main_restored", s5, 7'b1001000);

    // Asynchronous reset between edges drops every gate at once
    #2 rst_n = 1'b0;
    #1 chk("async_reset", s5, 7'b0000000);
    chk("async_reset0", s0, 7'b0000000);
    leg_en = 2'b01; leg_cmd = 2'b01;
    tick();
    rst_n = 1'b1;

`ifdef GATE_MIN_PULSE_EN
    // 6: command change early in UP is held off until the on-time expires
    tick();  chk("t6_dead", sm, 7'b0000010);
    tick(4);
    tick();  chk("t6_up_on", sm, 7'b0100000);
    tick(3);
    leg_cmd = 2'b00;
    tick(16); chk("t6_min_on_hold", sm, 7'b0100000);
    tick();   chk("t6_dead_at_20", sm, 7'b0000010);
`else
    tick();  chk("post_reset_dead", s5, 7'b0000010);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
